// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone host bridge.
// Bus widths, bridge state encoding and the error-response data value.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_DAT_W-1:0] RSP_ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/wb_host_bridge.sv
// Valid/ready request/response to single Wishbone classic cycles.
// One transaction in flight; a wait counter bounds slaves that never respond.
module wb_host_bridge
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [WB_ADR_W-1:0] req_adr,
    input  logic [WB_DAT_W-1:0] req_dat,
    input  logic [WB_SEL_W-1:0] req_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT - 1);

    bridge_state_t       state, state_n;
    logic [TO_W-1:0]     cnt, cnt_n;
    logic                cyc_n, we_n;
    logic [WB_ADR_W-1:0] adr_n;
    logic [WB_DAT_W-1:0] dat_n;
    logic [WB_SEL_W-1:0] sel_n;
    logic                rsp_valid_n, rsp_err_n, rsp_timeout_n;
    logic [WB_DAT_W-1:0] rsp_dat_n;

    assign req_ready = (state == ST_IDLE) && !wb_rst_i;
    assign wbm_stb_o = wbm_cyc_o;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        cyc_n         = wbm_cyc_o;
        we_n          = wbm_we_o;
        adr_n         = wbm_adr_o;
        dat_n         = wbm_dat_o;
        sel_n         = wbm_sel_o;
        rsp_valid_n   = rsp_valid;
        rsp_err_n     = rsp_err;
        rsp_timeout_n = rsp_timeout;
        rsp_dat_n     = rsp_dat;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    we_n    = req_we;
                    adr_n   = req_adr;
                    dat_n   = req_dat;
                    sel_n   = req_sel;
                    cyc_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_BUS;
                end
            end
            ST_BUS: begin
                // err outranks ack; a final-cycle ack still beats the timeout
                if (wbm_err_i || wbm_ack_i || cnt == LAST_WAIT) begin
                    cyc_n         = 1'b0;
                    cnt_n         = '0;
                    rsp_valid_n   = 1'b1;
                    rsp_err_n     = wbm_err_i || !wbm_ack_i;
                    rsp_timeout_n = !wbm_err_i && !wbm_ack_i;
                    rsp_dat_n     = RSP_ERR_DATA;
                    if (!wbm_err_i && wbm_ack_i && !wbm_we_o) begin
                        rsp_dat_n = wbm_dat_i;
                    end
                    state_n = ST_RESP;
                end else begin
                    cnt_n = cnt + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_dat     <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            wbm_cyc_o   <= cyc_n;
            wbm_we_o    <= we_n;
            wbm_adr_o   <= adr_n;
            wbm_dat_o   <= dat_n;
            wbm_sel_o   <= sel_n;
            rsp_valid   <= rsp_valid_n;
            rsp_err     <= rsp_err_n;
            rsp_timeout <= rsp_timeout_n;
            rsp_dat     <= rsp_dat_n;
        end
    end

endmodule

// File: tb/tb_wb_host_bridge.sv
// Directed bench for wb_host_bridge with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_host_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_host_bridge #(.TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_adr(req_adr),
        .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic request(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_we = w;
        req_adr = a;
        req_dat = d;
        req_sel = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_ready got %0b exp 0", req_ready);
        end
        checks++;
        if ({cyc, stb, we, adr, dat_o, sel} !== 71'h0) begin
            errors++;
            $display("FAIL reset_bus got cyc=%0b stb=%0b we=%0b adr=%h dat=%h sel=%h exp all 0",
                     cyc, stb, we, adr, dat_o, sel);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_dat} !== 35'h0) begin
            errors++;
            $display("FAIL reset_rsp got v=%0b e=%0b t=%0b d=%h exp all 0",
                     rsp_valid, rsp_err, rsp_timeout, rsp_dat);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %0b exp 1", req_ready);
        end
    endtask

    task automatic test_read();
        request(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        checks++;
        if ({cyc, stb, we, adr, sel} !== {3'b110, 32'h3000_0004, 4'hF}) begin
            errors++;
            $display("FAIL read_bus_c1 got cyc=%0b stb=%0b we=%0b adr=%h sel=%h exp 1 1 0 30000004 f",
                     cyc, stb, we, adr, sel);
        end
        tick();
        tick();
        checks++;
        if ({cyc, stb, rsp_valid} !== 3'b110) begin
            errors++;
            $display("FAIL read_bus_c3 got cyc=%0b stb=%0b rv=%0b exp 1 1 0", cyc, stb, rsp_valid);
        end
        ack = 1'b1;
        dat_i = 32'hCAFE_F00D;
        tick();
        ack = 1'b0;
        dat_i = 32'h0;
        checks++;
        if ({cyc, stb, rsp_valid, rsp_err, rsp_timeout} !== 5'b00100 ||
            rsp_dat !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL read_rsp got cyc=%0b stb=%0b v=%0b e=%0b t=%0b d=%h exp 0 0 1 0 0 cafef00d",
                     cyc, stb, rsp_valid, rsp_err, rsp_timeout, rsp_dat);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_resp_ready got %0b exp 0", req_ready);
        end
        consume();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_consume got v=%0b rr=%0b exp 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_write();
        dat_i = 32'hDEAD_BEEF;
        request(1'b1, 32'h3000_0000, 32'h1234_5678, 4'h3);
        checks++;
        if ({cyc, stb, we, adr, dat_o, sel} !==
            {3'b111, 32'h3000_0000, 32'h1234_5678, 4'h3}) begin
            errors++;
            $display("FAIL write_bus got cyc=%0b stb=%0b we=%0b adr=%h dat=%h sel=%h",
                     cyc, stb, we, adr, dat_o, sel);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({cyc, rsp_valid, rsp_err, rsp_timeout} !== 4'b0100 || rsp_dat !== 32'h0) begin
            errors++;
            $display("FAIL write_rsp got cyc=%0b v=%0b e=%0b t=%0b d=%h exp 0 1 0 0 0",
                     cyc, rsp_valid, rsp_err, rsp_timeout, rsp_dat);
        end
        checks++;
        if ({we, dat_o, sel} !== {1'b1, 32'h1234_5678, 4'h3}) begin
            errors++;
            $display("FAIL write_retain got we=%0b dat=%h sel=%h exp 1 12345678 3", we, dat_o, sel);
        end
        consume();
        dat_i = 32'h0;
    endtask

    task automatic test_timeout();
        int n;
        dat_i = 32'h5555_AAAA;
        request(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        n = 0;
        while (stb === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_stb_cycles got %0d exp 16", n);
        end
        checks++;
        if ({cyc, rsp_valid, rsp_err, rsp_timeout} !== 4'b0111 || rsp_dat !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp got cyc=%0b v=%0b e=%0b t=%0b d=%h exp 0 1 1 1 0",
                     cyc, rsp_valid, rsp_err, rsp_timeout, rsp_dat);
        end
        consume();

        request(1'b0, 32'h3000_0104, 32'h0, 4'hF);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (stb !== 1'b1) begin
            errors++;
            $display("FAIL timeout_c16_stb got %0b exp 1", stb);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_dat !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL late_ack_rsp got v=%0b e=%0b t=%0b d=%h exp 1 0 0 5555aaaa",
                     rsp_valid, rsp_err, rsp_timeout, rsp_dat);
        end
        consume();
        dat_i = 32'h0;
    endtask

    task automatic test_ack_err();
        request(1'b0, 32'h3000_0200, 32'h0, 4'hF);
        ack = 1'b1;
        err = 1'b1;
        dat_i = 32'h7777_1111;
        tick();
        ack = 1'b0;
        err = 1'b0;
        dat_i = 32'h0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_dat !== 32'h0) begin
            errors++;
            $display("FAIL ack_err_rsp got v=%0b e=%0b t=%0b d=%h exp 1 1 0 0",
                     rsp_valid, rsp_err, rsp_timeout, rsp_dat);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int bad;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_adr = 32'h3000_0300;
        req_sel = 4'hF;
        tick();
        req_adr = 32'h3000_0304;
        ack = 1'b1;
        dat_i = 32'hA5A5_0001;
        tick();
        ack = 1'b0;
        dat_i = 32'h0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'hA5A5_0001 ||
                rsp_err !== 1'b0 || req_ready !== 1'b0 || cyc !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, cyc} !== 3'b010) begin
            errors++;
            $display("FAIL backpressure_release got v=%0b rr=%0b cyc=%0b exp 0 1 0",
                     rsp_valid, req_ready, cyc);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (cyc !== 1'b1 || adr !== 32'h3000_0304) begin
            errors++;
            $display("FAIL backpressure_next got cyc=%0b adr=%h exp 1 30000304", cyc, adr);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        consume();
    endtask

    task automatic test_reset_mid();
        int bad;
        request(1'b0, 32'h3000_0400, 32'h0, 4'hF);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cyc, stb, rsp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_bus got cyc=%0b stb=%0b v=%0b exp 0 0 0", cyc, stb, rsp_valid);
        end
        ack = 1'b1;
        dat_i = 32'hBAD0_BAD0;
        tick();
        ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || cyc !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_stray got %0d bad cycles exp 0", bad);
        end
        dat_i = 32'h0;
        request(1'b0, 32'h3000_0408, 32'h0, 4'hF);
        ack = 1'b1;
        dat_i = 32'h0BAD_F00D;
        tick();
        ack = 1'b0;
        dat_i = 32'h0;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_dat !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL reset_mid_fresh got v=%0b e=%0b d=%h exp 1 0 0badf00d",
                     rsp_valid, rsp_err, rsp_dat);
        end
        consume();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_adr = '0;
        req_dat = '0;
        req_sel = '0;
        rsp_ready = 1'b0;
        dat_i = '0;
        ack = 1'b0;
        err = 1'b0;
        #1;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ack_err();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_host_bridge.md
Name: wb_host_bridge

Overview:
- Wishbone classic initiator that turns a simple valid/ready request/response handshake into single Wishbone read/write cycles.
- Intended to let on-chip designs, or a future pin-driven debug port, drive the same Wishbone slave fabric that the management SoC drives.
- One transaction in flight at a time.
- A bus timeout guarantees forward progress when the addressed slave never acknowledges.

Parameters:
- TIMEOUT, 16: maximum number of cycles stb may stay high without ack/err before the bridge aborts. Legal range 1..65535.
- TO_W, $clog2(TIMEOUT+1): width of the wait counter. Derived; never overridden.

Ports:
- wb_clk_i  in  1  single clock; all logic rising-edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  32  byte address.
- req_dat  in  32  write data.
- req_sel  in  4  byte lanes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  1 = slave error or timeout.
- rsp_timeout  out  1  1 = error was caused by timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_err_i  in  1  Wishbone error (tie 0 if unused).

Behaviour:
- Reset values, with wb_rst_i sampled high at a rising edge:
  - state = IDLE.
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 0; wbm_adr_o, wbm_dat_o, wbm_sel_o = 0.
  - rsp_valid = 0, rsp_dat = 0, rsp_err = 0, rsp_timeout = 0.
  - Wait counter = 0.
- req_ready is combinational: state == IDLE && !wb_rst_i.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On req_valid && req_ready at edge N, register we/adr/dat/sel onto the wbm_* outputs and enter BUS.
  - cyc = stb = 1 from cycle N+1. Request-to-bus latency is exactly 1 cycle.
- BUS:
  - cyc, stb, we, adr, dat and sel are held stable.
  - Each edge with neither ack nor err increments the wait counter.
  - Termination at edge M, on the first true condition:
    - wbm_err_i → rsp_err = 1, rsp_timeout = 0, rsp_dat = 0. err wins over a simultaneous ack.
    - wbm_ack_i → rsp_err = 0, rsp_timeout = 0; rsp_dat = wbm_dat_i for a read, 0 for a write.
    - Wait counter == TIMEOUT-1 with no ack/err → rsp_err = 1, rsp_timeout = 1, rsp_dat = 0.
  - An ack arriving on the final permitted cycle is a normal completion, not a timeout.
  - stb is high for at most TIMEOUT cycles.
  - On termination: cyc = stb = 0 and rsp_valid = 1 from cycle M+1, counter cleared, enter RESP.
  - No back-to-back cycles: cyc is always low for at least one cycle between transactions.
- RESP:
  - rsp_valid and the rsp_* fields are held stable until rsp_ready is sampled high.
  - On that edge: rsp_valid = 0, enter IDLE. req_ready returns high the following cycle.
  - A request cannot be accepted on the same edge a response is consumed.
- Late or stray ack/err while not in BUS is ignored.
- wbm_dat_i is sampled only on the terminating ack edge.
- Reset mid-transaction:
  - BUS: cyc/stb drop at the reset edge and the transaction is discarded. No response is ever produced.
  - RESP: the pending response is discarded.
- wbm_we_o, wbm_adr_o, wbm_dat_o and wbm_sel_o retain their last values after a cycle ends. Their values are meaningful only while cyc is high.

Decomposition:
- Shared package wb_pkg holds:
  - the bridge state enum (IDLE/BUS/RESP);
  - WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4;
  - localparam RSP_ERR_DATA = 32'h0.
- No sub-module: single module.
- A reusable bus-side Wishbone monitor belongs to the verification environment, not RTL.

Test Plan:
- Read, ack on 3rd stb cycle: req adr=0x3000_0004, we=0, sel=0xF at edge 0 → cyc/stb high cycles 1–3; ack with dat=0xCAFE_F00D at cycle 3 → cycle 4: cyc=0, rsp_valid=1, rsp_dat=0xCAFE_F00D, rsp_err=0.
- Write: adr=0x3000_0000, dat=0x1234_5678, sel=0x3, ack at first stb cycle → wbm_dat_o=0x1234_5678, wbm_sel_o=0x3, we=1 for 1 cycle; rsp_dat=0, rsp_err=0.
- Timeout, TIMEOUT=16, slave silent → stb high exactly 16 cycles; rsp_err=1, rsp_timeout=1, rsp_dat=0. Repeat with ack on the 16th cycle → rsp_err=0.
- Simultaneous ack and err on the same cycle → rsp_err=1, rsp_timeout=0, rsp_dat=0.
- Backpressure: hold rsp_ready=0 for 10 cycles, with req_valid held high throughout →
  - rsp_* stable and req_ready=0 the whole time;
  - rsp_ready=1 → rsp_valid drops next edge; the next request is accepted one cycle later;
  - cyc is low for ≥1 cycle between transactions.
- Reset asserted during BUS at the 2nd stb cycle → cyc/stb=0 the following cycle; rsp_valid never asserts; an ack arriving afterwards is ignored; a fresh read after reset completes normally.
